// File: rtl/pipeline_pkg.sv
// pipeline_pkg: shared types and constants for the 5-stage pipeline control logic
package pipeline_pkg;

    typedef enum logic {IDLE, BUSY} md_state_t;

    localparam logic [4:0] REG_ZERO           = 5'd0;
    localparam int         MD_LATENCY_DEFAULT = 4;

endpackage

// File: rtl/md_busy_counter.sv
// md_busy_counter: tracks the mult/div unit occupancy after an issue
module md_busy_counter
    import pipeline_pkg::*;
#(
    parameter int MD_LATENCY = MD_LATENCY_DEFAULT,
    parameter int CNT_W      = 3
)(
    input  logic clock,
    input  logic reset,
    input  logic i_issue,
    output logic o_busy
);

    md_state_t        r_state;
    logic [CNT_W-1:0] r_cnt;

    // Issue loads the latency; busy ends on the edge where the count reaches one
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_state <= IDLE;
            r_cnt   <= '0;
        end else if (r_state == IDLE) begin
            if (i_issue) begin
                r_state <= BUSY;
                r_cnt   <= CNT_W'(MD_LATENCY);
            end
        end else if (r_cnt == CNT_W'(1)) begin
            r_state <= IDLE;
            r_cnt   <= '0;
        end else begin
            r_cnt <= r_cnt - CNT_W'(1);
        end
    end

    assign o_busy = (r_state == BUSY);

endmodule

// File: rtl/hazard_detection_unit.sv
// hazard_detection_unit: load-use / mult-div stall and taken-branch flush control
module hazard_detection_unit
    import pipeline_pkg::*;
#(
    parameter int MD_LATENCY  = MD_LATENCY_DEFAULT,
    parameter int CNT_W       = 3,
    parameter int STALL_CNT_W = 16
)(
    input  logic                   clock,
    input  logic                   reset,
    input  logic [4:0]             if_id_rs,
    input  logic [4:0]             if_id_rt,
    input  logic                   id_uses_rt,
    input  logic                   id_md_start,
    input  logic                   id_reads_hilo,
    input  logic [4:0]             id_ex_rt,
    input  logic                   id_ex_memRead,
    input  logic                   branch_taken,
    output logic                   pcWrite,
    output logic                   if_id_write,
    output logic                   if_id_flush,
    output logic                   id_ex_bubble,
    output logic                   md_busy,
    output logic [STALL_CNT_W-1:0] stall_count
);

    logic                   w_load_use;
    logic                   w_md_haz;
    logic                   w_stall;
    logic                   w_issue;
    logic [STALL_CNT_W-1:0] r_stall_count;

    // A load into $0 never creates a dependency; rt only matters when ID reads it
    assign w_load_use = id_ex_memRead && (id_ex_rt != REG_ZERO) &&
                        ((id_ex_rt == if_id_rs) || (id_uses_rt && (id_ex_rt == if_id_rt)));
    assign w_md_haz   = md_busy && (id_md_start || id_reads_hilo);
    // Taken branch squashes ID, so it overrides any stall; reset forces free-run outputs
    assign w_stall    = reset && !branch_taken && (w_load_use || w_md_haz);
    assign w_issue    = reset && id_md_start && !branch_taken && !w_load_use;

    assign pcWrite      = !w_stall;
    assign if_id_write  = !w_stall;
    assign if_id_flush  = reset && branch_taken;
    assign id_ex_bubble = w_stall || (reset && branch_taken);
    assign stall_count  = r_stall_count;

    md_busy_counter #(
        .MD_LATENCY (MD_LATENCY),
        .CNT_W      (CNT_W)
    ) u_md_busy (
        .clock   (clock),
        .reset   (reset),
        .i_issue (w_issue),
        .o_busy  (md_busy)
    );

    // Count stalled cycles, saturating at all-ones
    always_ff @(posedge clock or negedge reset) begin
        if (!reset)
            r_stall_count <= '0;
        else if (w_stall && (r_stall_count != '1))
            r_stall_count <= r_stall_count + STALL_CNT_W'(1);
    end

endmodule

// File: tb/tb_hazard_detection_unit.sv
// tb_hazard_detection_unit: directed vector table plus multi-cycle sequences
module tb_hazard_detection_unit;
    import pipeline_pkg::*;

    logic        clock = 1'b0;
    logic        reset;
    logic [4:0]  if_id_rs, if_id_rt, id_ex_rt;
    logic        id_uses_rt, id_md_start, id_reads_hilo, id_ex_memRead, branch_taken;
    logic        pcWrite, if_id_write, if_id_flush, id_ex_bubble, md_busy;
    logic [15:0] stall_count;

    int n_vec = 0;
    int n_err = 0;
    int exp_cnt = 0;
    int busy_cycles;

    typedef struct {
        logic [4:0] rs, rt;
        logic       uses, mds, hilo;
        logic [4:0] ex_rt;
        logic       mr, br;
        logic       pcw, ifw, fl, bub;
    } vec_t;

    vec_t tbl[11];

    hazard_detection_unit dut (
        .clock         (clock),
        .reset         (reset),
        .if_id_rs      (if_id_rs),
        .if_id_rt      (if_id_rt),
        .id_uses_rt    (id_uses_rt),
        .id_md_start   (id_md_start),
        .id_reads_hilo (id_reads_hilo),
        .id_ex_rt      (id_ex_rt),
        .id_ex_memRead (id_ex_memRead),
        .branch_taken  (branch_taken),
        .pcWrite       (pcWrite),
        .if_id_write   (if_id_write),
        .if_id_flush   (if_id_flush),
        .id_ex_bubble  (id_ex_bubble),
        .md_busy       (md_busy),
        .stall_count   (stall_count)
    );

    always #5 clock = ~clock;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic drive(input logic [4:0] rs, input logic [4:0] rt, input logic uses,
                         input logic mds, input logic hilo, input logic [4:0] ex_rt,
                         input logic mr, input logic br);
        if_id_rs      = rs;
        if_id_rt      = rt;
        id_uses_rt    = uses;
        id_md_start   = mds;
        id_reads_hilo = hilo;
        id_ex_rt      = ex_rt;
        id_ex_memRead = mr;
        branch_taken  = br;
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    initial begin
        //             rs     rt     use   mds   hilo  ex_rt  mr    br    pcw   ifw   fl    bub
        tbl[0]  = '{5'd2, 5'd0, 1'b1, 1'b0, 1'b0, 5'd2, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1};
        tbl[1]  = '{5'd2, 5'd0, 1'b1, 1'b0, 1'b0, 5'd2, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0};
        tbl[2]  = '{5'd0, 5'd0, 1'b1, 1'b0, 1'b0, 5'd0, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0};
        tbl[3]  = '{5'd1, 5'd5, 1'b0, 1'b0, 1'b0, 5'd5, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0};
        tbl[4]  = '{5'd1, 5'd5, 1'b1, 1'b0, 1'b0, 5'd5, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1};
        tbl[5]  = '{5'd3, 5'd4, 1'b1, 1'b0, 1'b0, 5'd5, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0};
        tbl[6]  = '{5'd2, 5'd0, 1'b0, 1'b0, 1'b0, 5'd2, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1};
        tbl[7]  = '{5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1};
        tbl[8]  = '{5'd0, 5'd0, 1'b0, 1'b1, 1'b0, 5'd0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1};
        tbl[9]  = '{5'd7, 5'd0, 1'b0, 1'b1, 1'b0, 5'd7, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1};
        tbl[10] = '{5'd0, 5'd0, 1'b0, 1'b0, 1'b1, 5'd0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0};

        // Reset held with a load-use hazard and a mult present: outputs must free-run
        reset = 1'b0;
        drive(5'd2, 5'd0, 1'b1, 1'b1, 1'b0, 5'd2, 1'b1, 1'b0);
        #2;
        chk("rst_pcWrite", pcWrite, 1);
        chk("rst_if_id_write", if_id_write, 1);
        chk("rst_flush", if_id_flush, 0);
        chk("rst_bubble", id_ex_bubble, 0);
        tick();
        tick();
        chk("rst_md_busy", md_busy, 0);
        chk("rst_stall_count", stall_count, 0);
        drive(5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0);
        reset = 1'b1;

        // Single-cycle combinational vectors; mult never issues in any of them
        for (int i = 0; i < 11; i++) begin
            drive(tbl[i].rs, tbl[i].rt, tbl[i].uses, tbl[i].mds, tbl[i].hilo,
                  tbl[i].ex_rt, tbl[i].mr, tbl[i].br);
            #2;
            chk($sformatf("v%0d_pcWrite", i), pcWrite, tbl[i].pcw);
            chk($sformatf("v%0d_if_id_write", i), if_id_write, tbl[i].ifw);
            chk($sformatf("v%0d_flush", i), if_id_flush, tbl[i].fl);
            chk($sformatf("v%0d_bubble", i), id_ex_bubble, tbl[i].bub);
            if (!tbl[i].pcw) exp_cnt++;
            tick();
            chk($sformatf("v%0d_stall_count", i), stall_count, exp_cnt);
            chk($sformatf("v%0d_md_busy", i), md_busy, 0);
        end

        // Mult issues, mfhi waits out the four busy cycles then proceeds
        drive(5'd0, 5'd0, 1'b0, 1'b1, 1'b0, 5'd0, 1'b0, 1'b0);
        #2;
        chk("md_issue_pcWrite", pcWrite, 1);
        tick();
        drive(5'd0, 5'd0, 1'b0, 1'b0, 1'b1, 5'd0, 1'b0, 1'b0);
        for (int c = 1; c <= 4; c++) begin
            #2;
            chk($sformatf("md_c%0d_busy", c), md_busy, 1);
            chk($sformatf("md_c%0d_pcWrite", c), pcWrite, 0);
            chk($sformatf("md_c%0d_bubble", c), id_ex_bubble, 1);
            exp_cnt++;
            tick();
        end
        #2;
        chk("md_c5_busy", md_busy, 0);
        chk("md_c5_pcWrite", pcWrite, 1);
        chk("md_stall_count", stall_count, exp_cnt);
        tick();

        // Branch during busy keeps the op running; async reset aborts it
        drive(5'd0, 5'd0, 1'b0, 1'b1, 1'b0, 5'd0, 1'b0, 1'b0);
        tick();
        drive(5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b1);
        #2;
        chk("br_busy_flush", if_id_flush, 1);
        chk("br_busy_c1", md_busy, 1);
        tick();
        drive(5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0);
        #2;
        chk("br_busy_c2", md_busy, 1);
        reset = 1'b0;
        #1;
        chk("async_md_busy", md_busy, 0);
        chk("async_stall_count", stall_count, 0);
        exp_cnt = 0;
        tick();
        reset = 1'b1;
        drive(5'd0, 5'd0, 1'b0, 1'b1, 1'b0, 5'd0, 1'b0, 1'b0);
        tick();
        drive(5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0);
        busy_cycles = 0;
        for (int c = 0; c < 10; c++) begin
            if (md_busy) busy_cycles++;
            tick();
        end
        chk("post_rst_busy_cycles", busy_cycles, 4);

        // Continuous load-use stall drives the statistics counter into saturation
        drive(5'd9, 5'd0, 1'b0, 1'b0, 1'b0, 5'd9, 1'b1, 1'b0);
        repeat (65539) @(posedge clock);
        #1;
        chk("sat_stall_count", stall_count, 16'hFFFF);
        tick();
        chk("sat_hold", stall_count, 16'hFFFF);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
